xadc_da2_sequencer: RTL

Controller between the XADC wizard DRP port and the PmodDA2 DAC driver. On each XADC end-of-conversion it runs a DRP read of the converted channel and stores the 12-bit result in one of two channel slots. A rate-limited start/done handshake with the DA2 driver then pushes both slots to the DAC, replacing direct eoc-to-den wiring and free-running DAC start pulses.

---
 rtl/xadc_da2_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/xadc_da2_sequencer.sv
// XADC-to-PmodDA2 sequencer: reads converted channels over DRP on each eoc and
// pushes the two channel slots to the DA2 driver through a rate-limited start/done handshake.
`timescale 1ns/1ps

module xadc_da2_sequencer #(
    parameter logic [4:0] CH_A         = 5'h03,
    parameter logic [4:0] CH_B         = 5'h10,
    parameter int         DRDY_TIMEOUT = 16,
    parameter int         UPDATE_MIN   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic [4:0]  channel,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic        den,
    output logic [6:0]  daddr,
    output logic        dwe,
    input  logic        da2_done,
    output logic        da2_start,
    output logic [11:0] da2_data1,
    output logic [11:0] da2_data2,
    input  logic        clr_flags,
    output logic        overrun,
    output logic        timeout
);

    localparam int TW = $clog2(DRDY_TIMEOUT + 1);
    localparam int HW = $clog2(UPDATE_MIN + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(DRDY_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(UPDATE_MIN);

    typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT, D_STORE} drp_state_t;
    typedef enum logic [1:0] {A_IDLE, A_START, A_BUSY} dac_state_t;

    drp_state_t    d_state;
    dac_state_t    a_state;
    logic [1:0]    done_sync;
    logic          done_s;
    logic [4:0]    ch_q;
    logic [TW-1:0] wait_cnt;
    logic [11:0]   sample;
    logic [11:0]   slot_a;
    logic [11:0]   slot_b;
    logic          pending;
    logic [HW-1:0] holdoff;
    logic          store_ev;
    logic          load_ev;
    logic          expire_ev;
    logic          drop_ev;
    logic          unused_do_lsb;

    assign dwe           = 1'b0;
    assign done_s        = done_sync[1];
    assign unused_do_lsb = ^do_in[3:0];

    assign store_ev  = (d_state == D_STORE);
    assign load_ev   = (a_state == A_IDLE) && pending && (holdoff == '0);
    assign expire_ev = (d_state == D_WAIT) && !drdy && (wait_cnt == WAIT_LAST);
    assign drop_ev   = eoc && (d_state != D_IDLE);

    // DONE comes from the DA2 clock domain; idle-high so reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_sync <= 2'b11;
        end else begin
            done_sync <= {done_sync[0], da2_done};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state  <= D_IDLE;
            den      <= 1'b0;
            daddr    <= '0;
            ch_q     <= '0;
            wait_cnt <= '0;
            sample   <= '0;
            slot_a   <= '0;
            slot_b   <= '0;
        end else begin
            den <= 1'b0;
            case (d_state)
                D_IDLE: begin
                    if (eoc && (channel == CH_A || channel == CH_B)) begin
                        ch_q    <= channel;
                        den     <= 1'b1;
                        daddr   <= {2'b00, channel};
                        d_state <= D_REQ;
                    end
                end
                D_REQ: begin
                    wait_cnt <= '0;
                    d_state  <= D_WAIT;
                end
                D_WAIT: begin
                    // drdy on the final waiting cycle still wins over expiry
                    if (drdy) begin
                        sample  <= do_in[15:4];
                        d_state <= D_STORE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        d_state <= D_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                D_STORE: begin
                    if (ch_q == CH_A) begin
                        slot_a <= sample;
                    end else begin
                        slot_b <= sample;
                    end
                    d_state <= D_IDLE;
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_flags keeps the flag high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            overrun <= drop_ev   | (overrun & ~clr_flags);
            timeout <= expire_ev | (timeout & ~clr_flags);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            holdoff <= '0;
        end else begin
            pending <= store_ev | (pending & ~load_ev);
            if (load_ev) begin
                holdoff <= HOLD_LOAD;
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_state   <= A_IDLE;
            da2_start <= 1'b0;
            da2_data1 <= '0;
            da2_data2 <= '0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    // NOTE: non-blocking reads here see the slot values from before a coinciding
                    // store; pending stays set, so that sample goes out on the next update.
                    if (load_ev) begin
                        da2_data1 <= slot_a;
                        da2_data2 <= slot_b;
                        da2_start <= 1'b1;
                        a_state   <= A_START;
                    end
                end
                A_START: begin
                    if (!done_s) begin
                        da2_start <= 1'b0;
                        a_state   <= A_BUSY;
                    end
                end
                A_BUSY: begin
                    if (done_s) begin
                        a_state <= A_IDLE;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

endmodule
